// File: rtl/add_round_key_serial_if.sv
// ---------------------------------------------------------------------------
// add_round_key_serial_if
//   Bundles the three handshakes of the serial AddRoundKey stage:
//     state_in/state_valid/state_ready : 32*NB-bit state from MixColumns
//     key_word/key_valid/key_ready     : one 32-bit round-key word per column
//     state_out/out_valid/out_ready    : result towards the next round stage
//     round_idx/last_round             : round index of the block in flight
//   master : the environment (MixColumns, key schedule, next stage)
//   slave  : the add_round_key_serial block
// ---------------------------------------------------------------------------
interface add_round_key_serial_if #(
  parameter int NB = 4
);
  logic [32*NB-1:0] state_in;
  logic             state_valid;
  logic             state_ready;
  logic [31:0]      key_word;
  logic             key_valid;
  logic             key_ready;
  logic [32*NB-1:0] state_out;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       round_idx;
  logic             last_round;

  modport master (
    output state_in, state_valid, key_word, key_valid, out_ready,
    input  state_ready, key_ready, state_out, out_valid, round_idx, last_round
  );

  modport slave (
    input  state_in, state_valid, key_word, key_valid, out_ready,
    output state_ready, key_ready, state_out, out_valid, round_idx, last_round
  );
endinterface

// File: rtl/add_round_key_serial.sv
// ---------------------------------------------------------------------------
// add_round_key_serial
//   AES AddRoundKey applied one column per cycle. A state block is captured
//   from MixColumns, then NB round-key words are XORed into columns 0..NB-1
//   in order (column c = bits [32*NB-1-32c -: 32]). The finished state is
//   offered downstream until accepted; each accepted output advances
//   round_idx, wrapping NR -> 0.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : add_round_key_serial_if.slave (state, key and output streams)
// ---------------------------------------------------------------------------
module add_round_key_serial #(
  parameter int NB = 4,
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  add_round_key_serial_if.slave  bus
);

  localparam int W  = 32 * NB;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t            fsm_q, fsm_d;
  logic [W-1:0]    work_q, work_d;   // state being keyed
  logic [W-1:0]    out_q, out_d;     // published result
  logic [CW-1:0]   col_q, col_d;
  logic [3:0]      round_q, round_d;
  logic [W-1:0]    key_mask;
  logic [W-1:0]    work_xor;

  // Place the key word over the current column; column 0 is the MSB word.
  always_comb begin
    key_mask = W'(bus.key_word) << (32 * (NB - 1 - int'(col_q)));
    work_xor = work_q ^ key_mask;
  end

  // NOTE: every variable gets its hold value before the case so that no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    fsm_d   = fsm_q;
    work_d  = work_q;
    out_d   = out_q;
    col_d   = col_q;
    round_d = round_q;
    unique case (fsm_q)
      IDLE: begin
        if (bus.state_valid) begin
          work_d = bus.state_in;
          col_d  = '0;
          fsm_d  = KEY;
        end
      end
      KEY: begin
        if (bus.key_valid) begin
          work_d = work_xor;
          col_d  = col_q + 1'b1;
          if (col_q == CW'(NB - 1)) begin
            // state_out moves only here, so it never shows a partial block.
            out_d = work_xor;
            fsm_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_d   = IDLE;
          round_d = (round_q == 4'(NR)) ? 4'd0 : round_q + 4'd1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  // NOTE: the wide data registers are reset too, so an aborted block leaves
  // no residue visible on state_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      work_q  <= '0;
      out_q   <= '0;
      col_q   <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      work_q  <= work_d;
      out_q   <= out_d;
      col_q   <= col_d;
      round_q <= round_d;
    end
  end

  assign bus.state_ready = (fsm_q == IDLE);
  assign bus.key_ready   = (fsm_q == KEY);
  assign bus.out_valid   = (fsm_q == DONE);
  assign bus.state_out   = out_q;
  assign bus.round_idx   = round_q;
  assign bus.last_round  = (fsm_q == DONE) && (round_q == 4'(NR));

endmodule

// File: tb/tb_add_round_key_serial.sv
// ---------------------------------------------------------------------------
// tb_add_round_key_serial
//   Self-checking bench for add_round_key_serial. Expected results come from
//   a block-level model: state_out = state_in ^ {w0,w1,w2,w3}, and round_idx
//   counts accepted outputs modulo NR+1.
// ---------------------------------------------------------------------------
module tb_add_round_key_serial;
  localparam int NB = 4;
  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  add_round_key_serial_if #(.NB(NB)) bus ();

  add_round_key_serial #(.NB(NB), .NR(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_cmp = 0;
  int           n_bad = 0;
  int           exp_round = 0;
  logic [127:0] last_out = '0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ref_ark(input logic [127:0] s,
                                           input logic [31:0] k [4]);
    return s ^ {k[0], k[1], k[2], k[3]};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic idle_inputs();
    bus.state_valid = 1'b0;
    bus.key_valid   = 1'b0;
    bus.out_ready   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_round = 0;
    last_out  = '0;
    check("rst_state_ready", 128'(bus.state_ready), 128'(1));
    check("rst_key_ready",   128'(bus.key_ready),   128'(0));
    check("rst_out_valid",   128'(bus.out_valid),   128'(0));
    check("rst_round_idx",   128'(bus.round_idx),   128'(0));
    check("rst_state_out",   bus.state_out,         128'(0));
    check("rst_last_round",  128'(bus.last_round),  128'(0));
  endtask

  task automatic capture_state(input logic [127:0] st);
    int guard = 0;
    while (!bus.state_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("state_ready_idle", 128'(bus.state_ready), 128'(1));
    bus.state_in    = st;
    bus.state_valid = 1'b1;
    @(negedge clk);
    bus.state_valid = 1'b0;
    bus.state_in    = rnd128();
  endtask

  task automatic send_key(input logic [31:0] w, input int stall);
    repeat (stall) begin
      bus.key_valid = 1'b0;
      bus.key_word  = $urandom;
      @(negedge clk);
      check("stall_out_stable", bus.state_out, last_out);
      check("stall_no_valid",   128'(bus.out_valid), 128'(0));
    end
    check("key_ready", 128'(bus.key_ready), 128'(1));
    bus.key_word  = w;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // One full block: capture, NB key beats with stalls drawn from
  // [stall_lo, stall_hi], 'hold' cycles of back-pressure, then accept.
  task automatic run_block(input logic [127:0] st, input logic [31:0] k [4],
                           input int stall_lo, input int stall_hi,
                           input int hold, input bit toggle);
    logic [127:0] exp_out;
    int guard;
    exp_out = ref_ark(st, k);
    capture_state(st);
    for (int w = 0; w < NB; w++)
      send_key(k[w], int'($urandom_range(stall_hi, stall_lo)));
    check("out_valid_latency", 128'(bus.out_valid), 128'(1));
    guard = 0;
    while (!bus.out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("state_out",   bus.state_out,         exp_out);
    check("round_idx",   128'(bus.round_idx),   128'(exp_round));
    check("last_round",  128'(bus.last_round),  128'(exp_round == NR));
    check("done_sready", 128'(bus.state_ready), 128'(0));
    check("done_kready", 128'(bus.key_ready),   128'(0));
    repeat (hold) begin
      if (toggle) begin
        bus.state_valid = 1'($urandom);
        bus.key_valid   = 1'($urandom);
        bus.key_word    = $urandom;
        bus.state_in    = rnd128();
      end
      @(negedge clk);
      check("hold_state_out", bus.state_out,         exp_out);
      check("hold_round",     128'(bus.round_idx),   128'(exp_round));
      check("hold_valid",     128'(bus.out_valid),   128'(1));
      check("hold_sready",    128'(bus.state_ready), 128'(0));
      check("hold_kready",    128'(bus.key_ready),   128'(0));
    end
    bus.state_valid = 1'b0;
    bus.key_valid   = 1'b0;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    exp_round = (exp_round == NR) ? 0 : exp_round + 1;
    last_out  = exp_out;
    check("accept_valid_low",  128'(bus.out_valid),   128'(0));
    check("accept_sready",     128'(bus.state_ready), 128'(1));
    check("accept_round_next", 128'(bus.round_idx),   128'(exp_round));
    check("accept_out_held",   bus.state_out,         exp_out);
  endtask

  initial begin
    logic [31:0]  k [4];
    logic [31:0]  kz [4];
    logic [127:0] st;

    bus.state_in  = '0;
    bus.key_word  = '0;
    idle_inputs();
    rst_n = 1'b0;
    do_reset();

    // Known-answer round-0 block, no stalls.
    k = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    st = 128'h3243f6a8885a308d313198a2e0370734;
    run_block(st, k, 0, 0, 0, 1'b0);
    check("kat0_result", last_out, 128'h193de3bea0f4e22b9ac68d2ae9f84808);

    // Known-answer round-1 block, 3 idle cycles before each key word.
    k = '{32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605};
    st = 128'h046681e5e0cb199a48f8d37a2806264c;
    run_block(st, k, 3, 3, 0, 1'b0);
    check("kat1_result", last_out, 128'ha49c7ff2689f352b6b5bea43026a5049);

    // Back-pressure for 5 cycles with noise on the input handshakes.
    for (int i = 0; i < NB; i++) k[i] = $urandom;
    run_block(rnd128(), k, 0, 1, 5, 1'b1);

    // Reset after two key beats aborts the block.
    for (int i = 0; i < NB; i++) k[i] = $urandom;
    capture_state(rnd128());
    send_key(k[0], 0);
    send_key(k[1], 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_round = 0;
    last_out  = '0;
    check("abort_out_valid", 128'(bus.out_valid),   128'(0));
    check("abort_sready",    128'(bus.state_ready), 128'(1));
    check("abort_kready",    128'(bus.key_ready),   128'(0));
    check("abort_round",     128'(bus.round_idx),   128'(0));
    check("abort_state_out", bus.state_out,         128'(0));
    for (int i = 0; i < NB; i++) k[i] = $urandom;
    run_block(rnd128(), k, 0, 0, 0, 1'b0);

    // key_valid in IDLE must not be consumed.
    bus.key_valid = 1'b1;
    bus.key_word  = $urandom;
    repeat (3) begin
      @(negedge clk);
      check("idle_key_ready", 128'(bus.key_ready), 128'(0));
    end
    bus.key_valid = 1'b0;
    for (int i = 0; i < NB; i++) k[i] = $urandom;
    run_block(rnd128(), k, 0, 2, 0, 1'b0);

    // NR+1 zero-key blocks from round 0: last_round only on the final one.
    do_reset();
    kz = '{32'h0, 32'h0, 32'h0, 32'h0};
    for (int b = 0; b <= NR; b++) begin
      st = rnd128();
      run_block(st, kz, 0, 0, 0, 1'b0);
      check("zero_key_passthru", last_out, st);
    end
    check("round_wrapped", 128'(bus.round_idx), 128'(0));

    // Randomized blocks with random stalls and back-pressure.
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < NB; i++) k[i] = $urandom;
      run_block(rnd128(), k, 0, 3, int'($urandom_range(3, 0)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
